ps2_keyboard: RTL

//  PS/2 keyboard receiver for the VGA/keyboard I/O subsystem. Samples ps2_clk/ps2_data,

---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_fifo.sv | 41 ++++
 rtl/ps2_keyboard.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state type, frame constants and scancode-to-ASCII table for the PS/2 receiver.
package ps2_pkg;
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} ps2_state_e;
   localparam int         FRAME_BITS = 11;
   localparam logic [7:0] SC_BREAK   = 8'hF0;
   localparam logic [7:0] SC_EXT     = 8'hE0;
   localparam logic [7:0] SC_LSHIFT  = 8'h12;
   localparam logic [7:0] SC_RSHIFT  = 8'h59;

   // Returns 0 for codes with no printable/control mapping.
   function automatic logic [7:0] sc2ascii(input logic [7:0] sc, input logic shift);
      logic [7:0] a;
      a = 8'h00;
      case (sc)
         8'h1C: a = "a";  8'h32: a = "b";  8'h21: a = "c";  8'h23: a = "d";
         8'h24: a = "e";  8'h2B: a = "f";  8'h34: a = "g";  8'h33: a = "h";
         8'h43: a = "i";  8'h3B: a = "j";  8'h42: a = "k";  8'h4B: a = "l";
         8'h3A: a = "m";  8'h31: a = "n";  8'h44: a = "o";  8'h4D: a = "p";
         8'h15: a = "q";  8'h2D: a = "r";  8'h1B: a = "s";  8'h2C: a = "t";
         8'h3C: a = "u";  8'h2A: a = "v";  8'h1D: a = "w";  8'h22: a = "x";
         8'h35: a = "y";  8'h1A: a = "z";
         8'h16: a = shift ? "!" : "1";  8'h1E: a = shift ? "@" : "2";
         8'h26: a = shift ? "#" : "3";  8'h25: a = shift ? "$" : "4";
         8'h2E: a = shift ? "%" : "5";  8'h36: a = shift ? "^" : "6";
         8'h3D: a = shift ? "&" : "7";  8'h3E: a = shift ? "*" : "8";
         8'h46: a = shift ? "(" : "9";  8'h45: a = shift ? ")" : "0";
         8'h29: a = " ";
         8'h5A: a = 8'h0A;
         8'h66: a = 8'h08;
         default: a = 8'h00;
      endcase
      if (shift && a >= "a" && a <= "z") a = a - 8'h20;
      return a;
   endfunction
endpackage

// File: rtl/ps2_fifo.sv
// ps2_fifo: first-word fall-through receive FIFO; pop wins room for a same-cycle push when full.
module ps2_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic          do_pop, do_push;

   assign empty_o = cnt_q == '0;
   assign full_o  = cnt_q == (AW+1)'(DEPTH);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign dout_o  = empty_o ? '0 : mem[rd_q];

   always_ff @(posedge clk_i)
      if (do_push) mem[wr_q] <= din_i;

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_q + AW'(do_push);
         rd_q  <= rd_q + AW'(do_pop);
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
endmodule

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 device-to-host receiver (synchroniser, clock glitch filter, deframer, FIFO).
// Define PS2_ASCII_EN to translate make codes to ASCII ahead of the FIFO.
module ps2_keyboard
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int FILTER_LEN  = 4,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       sys_clk_i,
   input  logic       rst_ni,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   input  logic       rd_en_i,
   input  logic       clr_err_i,
   output logic [7:0] data_out_o,
   output logic       valid_o,
   output logic       overflow_o,
   output logic       parity_err_o
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [1:0]    clk_sync_q, dat_sync_q;
   logic          clk_filt_q;
   logic [FW-1:0] filt_cnt_q;
   ps2_state_e    state_q;
   logic [7:0]    sr_q;
   logic [2:0]    bit_q;
   logic          bad_q, par_q, err_q, ovf_q;
   logic [TW-1:0] tmo_q;
   logic          fall, din, rx_v, push, full, empty;
   logic [7:0]    rx_b, push_b;

   // A level change is accepted only after FILTER_LEN consecutive differing samples.
   assign fall = clk_filt_q && !clk_sync_q[1] && filt_cnt_q == FW'(FILTER_LEN - 1);
   assign din  = dat_sync_q[1];
   assign rx_v = fall && state_q == S_STOP && !bad_q && par_q && din;
   assign rx_b = sr_q;

   always_ff @(posedge sys_clk_i or negedge rst_ni)
      if (!rst_ni) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
         clk_filt_q <= 1'b1;
         filt_cnt_q <= '0;
      end else begin
         clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
         dat_sync_q <= {dat_sync_q[0], ps2_data_i};
         if (clk_sync_q[1] == clk_filt_q) filt_cnt_q <= '0;
         else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            clk_filt_q <= clk_sync_q[1];
            filt_cnt_q <= '0;
         end else filt_cnt_q <= filt_cnt_q + 1'b1;
      end

   // Each state consumes the bit named by the edge it waits for; a bad start bit is only reported at stop.
   always_ff @(posedge sys_clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q <= S_IDLE;
         sr_q    <= '0;
         bit_q   <= '0;
         bad_q   <= 1'b0;
         par_q   <= 1'b0;
         err_q   <= 1'b0;
         tmo_q   <= '0;
      end else begin
         err_q <= 1'b0;
         tmo_q <= (fall || state_q == S_IDLE) ? '0 : tmo_q + 1'b1;
         if (fall) begin
            case (state_q)
               S_IDLE: begin
                  bad_q   <= din;
                  state_q <= S_START;
               end
               S_START: begin
                  sr_q    <= {din, sr_q[7:1]};
                  bit_q   <= 3'd1;
                  state_q <= S_DATA;
               end
               S_DATA: begin
                  sr_q  <= {din, sr_q[7:1]};
                  bit_q <= bit_q + 3'd1;
                  if (bit_q == 3'd7) state_q <= S_PARITY;
               end
               S_PARITY: begin
                  par_q   <= ^{sr_q, din};
                  state_q <= S_STOP;
               end
               default: begin
                  err_q   <= !rx_v;
                  state_q <= S_IDLE;
               end
            endcase
         end else if (state_q != S_IDLE && tmo_q == TW'(TIMEOUT_CYC - 1)) state_q <= S_IDLE;
      end

`ifdef PS2_ASCII_EN
   logic       brk_q, ext_q, lsh_q, rsh_q, tx_v_q;
   logic [7:0] tx_b_q, asc;

   assign asc = sc2ascii(rx_b, lsh_q || rsh_q);

   always_ff @(posedge sys_clk_i or negedge rst_ni)
      if (!rst_ni) begin
         brk_q  <= 1'b0;
         ext_q  <= 1'b0;
         lsh_q  <= 1'b0;
         rsh_q  <= 1'b0;
         tx_v_q <= 1'b0;
         tx_b_q <= '0;
      end else begin
         tx_v_q <= 1'b0;
         if (rx_v) begin
            if (rx_b == SC_BREAK) brk_q <= 1'b1;
            else if (rx_b == SC_EXT) ext_q <= 1'b1;
            else begin
               brk_q <= 1'b0;
               ext_q <= 1'b0;
               if (!ext_q && rx_b == SC_LSHIFT) lsh_q <= !brk_q;
               else if (!ext_q && rx_b == SC_RSHIFT) rsh_q <= !brk_q;
               else if (!brk_q && !ext_q && asc != 8'h00) begin
                  tx_v_q <= 1'b1;
                  tx_b_q <= asc;
               end
            end
         end
      end

   assign push   = tx_v_q;
   assign push_b = tx_b_q;
`else
   assign push   = rx_v;
   assign push_b = rx_b;
`endif

   ps2_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
      .clk_i  (sys_clk_i),
      .rst_ni (rst_ni),
      .push_i (push),
      .din_i  (push_b),
      .pop_i  (rd_en_i),
      .dout_o (data_out_o),
      .full_o (full),
      .empty_o(empty)
   );

   always_ff @(posedge sys_clk_i or negedge rst_ni)
      if (!rst_ni) ovf_q <= 1'b0;
      else if (push && full && !rd_en_i) ovf_q <= 1'b1;
      else if (clr_err_i) ovf_q <= 1'b0;

   assign valid_o      = !empty;
   assign overflow_o   = ovf_q;
   assign parity_err_o = err_q;
endmodule
